// File: rtl/pa_fpu.sv
// pa_fpu: shared FPU types and constants (divider FSM states, IEEE specials, unpacked operand).
package pa_fpu;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_LZ_W  = $clog2(FP_MAN_W + 1);

    localparam logic [31:0] QNAN    = 32'h7fc00000;
    localparam logic [31:0] POS_INF = 32'h7f800000;

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} e_div_state;

    typedef struct packed {
        logic                       sign;
        logic signed [FP_EXP_W+1:0] exp;
        logic [FP_MAN_W:0]          mant;
        logic                       is_zero;
        logic                       is_inf;
        logic                       is_nan;
    } st_fp_unpacked;

    // Subnormals come out normalised: mantissa shifted so the leading one sits at the hidden-bit position.
    function automatic st_fp_unpacked fp_unpack(input logic [FP_EXP_W+FP_MAN_W:0] p,
                                                input logic [FP_LZ_W-1:0] lz);
        st_fp_unpacked u;
        logic [FP_EXP_W-1:0] ef;
        logic [FP_MAN_W-1:0] mf;
        ef        = p[FP_MAN_W +: FP_EXP_W];
        mf        = p[FP_MAN_W-1:0];
        u.sign    = p[FP_EXP_W+FP_MAN_W];
        u.is_nan  = (&ef) & (|mf);
        u.is_inf  = (&ef) & ~(|mf);
        u.is_zero = ~(|ef) & ~(|mf);
        u.exp     = (|ef) ? signed'({2'b00, ef}) : -signed'({{(FP_EXP_W+2-FP_LZ_W){1'b0}}, lz});
        u.mant    = (|ef) ? {1'b1, mf} : ({mf, 1'b0} << lz);
        return u;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// fpu_lzc: combinational leading-zero counter; an all-zero input reports W.
module fpu_lzc #(
    parameter int W  = 23,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++)
            if (value[i]) count = CW'(W - 1 - i);
    end

endmodule

// File: rtl/fpu_div_seq.sv
// fpu_div_seq: sequential IEEE-754 single-precision divider, restoring radix-2, round-to-nearest-even.
// Fixed latency: specials finish two cycles after start, finite operands after MAN_W+6 cycles.
module fpu_div_seq
    import pa_fpu::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a_operand,
    input  logic [EXP_W+MAN_W:0]   b_operand,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   ieee_packet_out,
    output logic                   div_by_zero,
    output logic                   invalid
);

    localparam int PW    = EXP_W + MAN_W + 1;
    localparam int BIAS  = 2**(EXP_W-1) - 1;
    localparam int ITER  = MAN_W + 4;
    localparam int EW    = EXP_W + 2;
    localparam int MW    = MAN_W + 1;
    localparam int FW    = MAN_W + 3;
    localparam int CNT_W = $clog2(ITER);
    localparam int LZ_W  = $clog2(MAN_W + 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] E_MAX  = EW'(2**EXP_W - 1);

    e_div_state              state;
    logic [PW-1:0]           a_q, b_q;
    logic                    sign_q;
    logic signed [EW-1:0]    e_q;
    logic [MW-1:0]           mb_q;
    logic [MW:0]             rem_q;
    logic [ITER-1:0]         q_q;
    logic [CNT_W-1:0]        cnt;

    logic [LZ_W-1:0]         lz_a, lz_b;
    st_fp_unpacked           ua, ub;

    fpu_lzc #(.W(MAN_W)) u_lzc_a (.value(a_q[MAN_W-1:0]), .count(lz_a));
    fpu_lzc #(.W(MAN_W)) u_lzc_b (.value(b_q[MAN_W-1:0]), .count(lz_b));

    assign ua = fp_unpack(a_q, lz_a);
    assign ub = fp_unpack(b_q, lz_b);

    logic              sgn, special, nan_case, sp_dbz, q0, qb;
    logic [PW-1:0]     sp_res;
    logic [MW:0]       rem0, rem_nx;
    logic [MW-1:0]     diff_m;
    logic signed [EW-1:0] e0;

    assign sgn      = ua.sign ^ ub.sign;
    assign special  = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf | ua.is_zero | ub.is_zero;
    assign nan_case = ua.is_nan | ub.is_nan | (ua.is_zero & ub.is_zero) | (ua.is_inf & ub.is_inf);
    assign sp_dbz   = ~nan_case & ub.is_zero & ~ua.is_inf;
    assign sp_res   = nan_case ? QNAN :
                      (ua.is_inf | ub.is_zero) ? {sgn, POS_INF[PW-2:0]} : {sgn, (PW-1)'(0)};
    assign e0       = ua.exp - ub.exp + E_BIAS;

    // The integer quotient bit is resolved during UNPACK, leaving ITER-1 steps for DIVIDE.
    assign q0     = ua.mant >= ub.mant;
    assign rem0   = {(q0 ? ua.mant - ub.mant : ua.mant), 1'b0};
    assign qb     = rem_q >= {1'b0, mb_q};
    assign diff_m = rem_q[MW-1:0] - mb_q;
    assign rem_nx = {(qb ? diff_m : rem_q[MW-1:0]), 1'b0};

    logic                 hi, sub, ovf, s0, lost, inc;
    logic [FW-1:0]        f, f_sh;
    logic signed [EW-1:0] e_n;
    logic [EW-1:0]        sh_raw, sh;
    logic [EXP_W-1:0]     e_base;
    logic [PW-2:0]        body;
    logic [PW-1:0]        rnd_res;

    assign hi      = q_q[ITER-1];
    assign f       = hi ? q_q[ITER-1:1] : q_q[ITER-2:0];
    assign s0      = (hi & q_q[0]) | (|rem_q);
    assign e_n     = hi ? e_q : e_q - E_ONE;
    assign ovf     = e_n >= E_MAX;
    assign sub     = e_n < E_ONE;
    assign sh_raw  = E_ONE - e_n;
    assign sh      = !sub ? '0 : (sh_raw > EW'(FW)) ? EW'(FW) : sh_raw;
    assign f_sh    = f >> sh;
    assign lost    = (f_sh << sh) != f;
    assign inc     = f_sh[1] & (f_sh[0] | lost | s0 | f_sh[2]);
    // Hidden bit adds back into the exponent LSB, so a rounding carry naturally bumps the exponent.
    assign e_base  = sub ? '0 : e_n[EXP_W-1:0] - EXP_W'(1);
    assign body    = {e_base, {MAN_W{1'b0}}} + (PW-1)'(f_sh[FW-1:2]) + (PW-1)'(inc);
    assign rnd_res = ovf ? {sign_q, POS_INF[PW-2:0]} : {sign_q, body};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state           <= IDLE;
            a_q             <= '0;
            b_q             <= '0;
            sign_q          <= 1'b0;
            e_q             <= '0;
            mb_q            <= '0;
            rem_q           <= '0;
            q_q             <= '0;
            cnt             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            ieee_packet_out <= '0;
            div_by_zero     <= 1'b0;
            invalid         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= a_operand;
                        b_q   <= b_operand;
                        busy  <= 1'b1;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q <= sgn;
                    if (special) begin
                        ieee_packet_out <= sp_res;
                        invalid         <= nan_case;
                        div_by_zero     <= sp_dbz;
                        done            <= 1'b1;
                        state           <= DONE;
                    end else begin
                        e_q   <= e0;
                        mb_q  <= ub.mant;
                        rem_q <= rem0;
                        q_q   <= {{(ITER-1){1'b0}}, q0};
                        cnt   <= CNT_W'(ITER - 2);
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    q_q   <= {q_q[ITER-2:0], qb};
                    rem_q <= rem_nx;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) state <= ROUND;
                end
                ROUND: begin
                    ieee_packet_out <= rnd_res;
                    invalid         <= 1'b0;
                    div_by_zero     <= 1'b0;
                    done            <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div_seq.sv
// tb_fpu_div_seq: directed vectors for fpu_div_seq with hand-computed quotients, flags and latencies.
module tb_fpu_div_seq;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_operand = '0;
    logic [31:0] b_operand = '0;
    logic        busy, done, div_by_zero, invalid;
    logic [31:0] ieee_packet_out;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_div_seq dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .a_operand(a_operand), .b_operand(b_operand),
        .busy(busy), .done(done), .ieee_packet_out(ieee_packet_out),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Cycle k is the interval after the k-th rising edge counted from the edge that samples start.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_dbz, input logic exp_inv,
                          input int exp_lat, input int glitch = 0, input logic glitch_done = 1'b0);
        int   lat = 0;
        logic busy_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        a_operand = a;
        b_operand = b;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                start = glitch_done;
                break;
            end
            if (k == glitch) begin
                start = 1'b1;
                a_operand = 32'h40c00000;
                b_operand = 32'h40000000;
            end else start = 1'b0;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, ieee_packet_out, exp_res);
        check({tag, "_flags"}, {30'b0, div_by_zero, invalid}, {30'b0, exp_dbz, exp_inv});
        check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_post"}, {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        logic saw_done;
        repeat (3) @(negedge clk);
        check("rst_out", ieee_packet_out, 32'h0);
        check("rst_ctl", {28'b0, busy, done, div_by_zero, invalid}, 32'h0);
        arst_n = 1'b1;

        do_div("half",     32'h3f800000, 32'h40000000, 32'h3f000000, 1'b0, 1'b0, 29);
        do_div("third",    32'h3f800000, 32'h40400000, 32'h3eaaaaab, 1'b0, 1'b0, 29);
        do_div("exact",    32'h40c00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 29);

        do_div("dbz",      32'h3f800000, 32'h00000000, 32'h7f800000, 1'b1, 1'b0, 2);
        do_div("zz",       32'h00000000, 32'h00000000, 32'h7fc00000, 1'b0, 1'b1, 2);
        do_div("nan",      32'h7fc00000, 32'h402df854, 32'h7fc00000, 1'b0, 1'b1, 2);
        do_div("infneg",   32'h7f800000, 32'hbf800000, 32'hff800000, 1'b0, 1'b0, 2);
        do_div("ii",       32'h7f800000, 32'hff800000, 32'h7fc00000, 1'b0, 1'b1, 2);
        do_div("inf0",     32'h7f800000, 32'h00000000, 32'h7f800000, 1'b0, 1'b0, 2);
        do_div("zinf",     32'h00000000, 32'h7f800000, 32'h00000000, 1'b0, 1'b0, 2);
        do_div("nzero",    32'h80000000, 32'h3f800000, 32'h80000000, 1'b0, 1'b0, 2);

        do_div("sub1",     32'h00000001, 32'h3f800000, 32'h00000001, 1'b0, 1'b0, 29);
        do_div("minnorm2", 32'h00800000, 32'h40000000, 32'h00400000, 1'b0, 1'b0, 29);
        do_div("tie_even", 32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 29);
        do_div("tie_up",   32'h00000003, 32'h40000000, 32'h00000002, 1'b0, 1'b0, 29);
        do_div("sub_norm", 32'h00000001, 32'h34000000, 32'h00800000, 1'b0, 1'b0, 29);
        do_div("sub_sub",  32'h00000001, 32'h00000001, 32'h3f800000, 1'b0, 1'b0, 29);

        do_div("ovf",      32'h7f7fffff, 32'h3f000000, 32'h7f800000, 1'b0, 1'b0, 29);
        do_div("ovf_sub",  32'h7f7fffff, 32'h00000001, 32'h7f800000, 1'b0, 1'b0, 29);
        do_div("unf",      32'h00800000, 32'h4b800000, 32'h00000000, 1'b0, 1'b0, 29);
        do_div("negmin",   32'h80800000, 32'h3f800000, 32'h80800000, 1'b0, 1'b0, 29);

        do_div("ignore",   32'h3f800000, 32'h40400000, 32'h3eaaaaab, 1'b0, 1'b0, 29, 5, 1'b1);

        @(negedge clk);
        start = 1'b1;
        a_operand = 32'h3f800000;
        b_operand = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("abort_out", ieee_packet_out, 32'h0);
        check("abort_ctl", {28'b0, busy, done, div_by_zero, invalid}, 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_quiet", {31'b0, saw_done}, 32'd0);

        do_div("after_rst", 32'h3f800000, 32'h40000000, 32'h3f000000, 1'b0, 1'b0, 29);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
